// File: rtl/regseq_pkg.sv
// Shared types and default widths for the register-file access sequencer.
package regseq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer: result, zero flag, and carry/no-borrow for ADD/SUB.
module regseq_alu
  import regseq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]   wide;
  logic [SH_W-1:0]   shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      // SUB as a + ~b + 1 so bit DATA_W is the no-borrow flag
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_PASS: result = a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_access_sequencer.sv
// Register-file initiator: accept command, read two sources, execute, optionally write back, respond.
// Optional macro REGSEQ_ZERO_REG_EN makes register 0 read as zero and suppresses writes to it.
module regfile_access_sequencer
  import regseq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [2:0]        CmdOp,
  input  logic [ADDR_W-1:0] CmdRs1,
  input  logic [ADDR_W-1:0] CmdRs2,
  input  logic [ADDR_W-1:0] CmdRd,
  input  logic              CmdWe,
  output logic              RfMode,
  output logic [ADDR_W-1:0] RfReadAddress1,
  output logic [ADDR_W-1:0] RfReadAddress2,
  input  logic [DATA_W-1:0] RfReadValue1,
  input  logic [DATA_W-1:0] RfReadValue2,
  output logic [ADDR_W-1:0] RfWriteAddress,
  output logic [DATA_W-1:0] RfWriteValue,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspZero,
  output logic              RspCarry,
  output logic              Busy
);

  state_e            state, state_nxt;

  op_e               op_p0;
  logic [ADDR_W-1:0] rs1_p0, rs2_p0, rd_p0;
  logic              we_p0;

  logic [DATA_W-1:0] opa_p1, opb_p1;
  logic [DATA_W-1:0] opa_in, opb_in;

  logic [DATA_W-1:0] result_p2;
  logic              zero_p2, carry_p2;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_carry;
  logic              skip_write;

`ifdef REGSEQ_ZERO_REG_EN
  assign opa_in     = (rs1_p0 == '0) ? '0 : RfReadValue1;
  assign opb_in     = (rs2_p0 == '0) ? '0 : RfReadValue2;
  assign skip_write = (rd_p0 == '0);
`else
  assign opa_in     = RfReadValue1;
  assign opb_in     = RfReadValue2;
  assign skip_write = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (CmdValid) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (we_p0 && !skip_write) ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  if (RspReady) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Stage 0: command latch on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0  <= OP_ADD;
      rs1_p0 <= '0;
      rs2_p0 <= '0;
      rd_p0  <= '0;
      we_p0  <= 1'b0;
    end else if (state == ST_IDLE && CmdValid) begin
      op_p0  <= op_e'(CmdOp);
      rs1_p0 <= CmdRs1;
      rs2_p0 <= CmdRs2;
      rd_p0  <= CmdRd;
      we_p0  <= CmdWe;
    end
  end

  // Stage 1: operand capture at the end of READ
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p1 <= '0;
      opb_p1 <= '0;
    end else if (state == ST_READ) begin
      opa_p1 <= opa_in;
      opb_p1 <= opb_in;
    end
  end

  regseq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_p0),
    .a      (opa_p1),
    .b      (opb_p1),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  // Stage 2: result and flags registered at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p2 <= '0;
      zero_p2   <= 1'b0;
      carry_p2  <= 1'b0;
    end else if (state == ST_EXEC) begin
      result_p2 <= alu_result;
      zero_p2   <= alu_zero;
      carry_p2  <= alu_carry;
    end
  end

  assign CmdReady       = (state == ST_IDLE);
  assign Busy           = (state != ST_IDLE);
  assign RfMode         = (state == ST_WRITE);
  assign RspValid       = (state == ST_RESP);
  assign RfReadAddress1 = rs1_p0;
  assign RfReadAddress2 = rs2_p0;
  assign RfWriteAddress = rd_p0;
  assign RfWriteValue   = result_p2;
  assign RspData        = result_p2;
  assign RspZero        = zero_p2;
  assign RspCarry       = carry_p2;

endmodule
